instruction_assembler: RTL and testbench

Front-end of the GPU command path, directly upstream of the pixel generator. It collects a byte stream from the host link (UART/SPI receiver), assembles 32-bit little-endian instruction words, and buffers them in a small FIFO. It issues them to the pixel generator as single-cycle pulses, and only while vertical blanking is active, so the background colour never changes mid-frame.

---
 rtl/gpu_pkg.sv | 24 ++
 rtl/instruction_assembler_if.sv | 49 ++++
 rtl/sync_fifo.sv | 93 +++++++++
 rtl/instruction_assembler.sv | 125 ++++++++++++
 tb/tb_instruction_assembler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Definitions shared by the GPU command path. The instruction assembler
// builds words in this format and the pixel generator decodes against the
// same opcodes.
//   INSTR_W         : width of one instruction word
//   OPCODE_W        : width of the opcode field, held in the low bits
//   BYTES_PER_INSTR : number of link bytes that make up one word
//   opcode_e        : known opcodes
//   instr_t         : one instruction word
// ---------------------------------------------------------------------------
package gpu_pkg;

   localparam int INSTR_W         = 32;
   localparam int OPCODE_W        = 8;
   localparam int BYTES_PER_INSTR = INSTR_W / 8;

   typedef enum logic [OPCODE_W-1:0] {
      SET_BG_COLOR = 8'h01
   } opcode_e;

   typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/instruction_assembler_if.sv
// ---------------------------------------------------------------------------
// instruction_assembler_if
// Bundles the byte-link input, the vblank qualifier and the instruction
// output side of the instruction assembler.
//   slave modport  : used by the assembler itself
//   master modport : used by whatever drives the link and consumes words
// Signals:
//   i_byte / i_byte_valid : received byte and its one-cycle strobe
//   i_vblank              : display is in vertical blanking
//   o_instruction         : last issued instruction word
//   o_instruction_ready   : one-cycle pulse marking a newly issued word
//   o_overflow            : sticky, a completed word was dropped
//   o_fifo_count          : number of words currently buffered
// ---------------------------------------------------------------------------
interface instruction_assembler_if
   import gpu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
);

   logic [7:0]                    i_byte;
   logic                          i_byte_valid;
   logic                          i_vblank;
   instr_t                        o_instruction;
   logic                          o_instruction_ready;
   logic                          o_overflow;
   logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;

   modport slave (
      input  i_byte,
      input  i_byte_valid,
      input  i_vblank,
      output o_instruction,
      output o_instruction_ready,
      output o_overflow,
      output o_fifo_count
   );

   modport master (
      output i_byte,
      output i_byte_valid,
      output i_vblank,
      input  o_instruction,
      input  o_instruction_ready,
      input  o_overflow,
      input  o_fifo_count
   );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered read port. The read register loads the
// head word on a pop and holds it otherwise, so it can drive an output
// directly.
// Parameters: WIDTH (data width), DEPTH (power of 2, at least 2)
// Ports:
//   clk_i, reset_i : clock and synchronous active-high reset
//   push_i         : write pushData_i; taken when not full or when a pop
//                    happens in the same cycle
//   pushData_i     : data to write
//   pop_i          : read the head; ignored when empty
//   popData_o      : registered head word from the last pop
//   count_o        : number of words held
//   full_o/empty_o : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         pushData_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         popData_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] popData_q, popData_d;
   logic             doPush;
   logic             doPop;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign popData_o = popData_q;

   // A full FIFO still takes a write when a read frees the slot on the same
   // edge; the read sees the old head because memory updates after the edge.
   always_comb begin
      doPop     = pop_i && !empty_o;
      doPush    = push_i && (!full_o || doPop);
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      count_d   = count_q;
      popData_d = popData_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
         rdPtr_d   = rdPtr_q + PTR_W'(1);
         popData_d = mem_q[rdPtr_q];
      end
      if (doPush && !doPop) begin
         count_d = count_q + CNT_W'(1);
      end else if (doPop && !doPush) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointers, occupancy and read register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         popData_q <= '0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         popData_q <= popData_d;
      end
   end

   // Storage is left unreset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

endmodule

// File: rtl/instruction_assembler.sv
// ---------------------------------------------------------------------------
// instruction_assembler
// Collects link bytes into 32-bit little-endian instruction words (first
// byte is the opcode), buffers them, and issues them as one-cycle pulses
// only while vertical blanking is active. A partial word that stalls for
// TIMEOUT_CYCLES is discarded.
// Parameters: FIFO_DEPTH (power of 2, >= 2), TIMEOUT_CYCLES (>= 2)
// Ports:
//   i_clk   : system/pixel clock
//   i_reset : synchronous active-high reset
//   bus     : byte input, vblank and instruction output (slave modport)
// ---------------------------------------------------------------------------
module instruction_assembler
   import gpu_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 250000
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   instruction_assembler_if.slave  bus
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W  = $clog2(BYTES_PER_INSTR);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
   localparam int HELD_W = INSTR_W - 8;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_INSTR - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [HELD_W-1:0] held_q, held_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              overflow_q, overflow_d;
   logic              ready_q, ready_d;

   logic              pushReq;
   instr_t            pushWord;
   logic              pop;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [CNT_W-1:0]  fifoCount;
   instr_t            headWord;

   // Byte assembly and stall timeout. The last byte is not stored; it goes
   // straight into the pushed word alongside the three held bytes. A byte
   // arriving on the timeout cycle wins over the discard.
   always_comb begin
      idx_d    = idx_q;
      held_d   = held_q;
      idle_d   = idle_q;
      pushReq  = 1'b0;
      pushWord = {bus.i_byte, held_q};
      if (bus.i_byte_valid) begin
         idle_d = '0;
         if (idx_q == LAST_IDX) begin
            pushReq = 1'b1;
            idx_d   = '0;
         end else begin
            case (idx_q)
               2'd0:    held_d[7:0]   = bus.i_byte;
               2'd1:    held_d[15:8]  = bus.i_byte;
               default: held_d[23:16] = bus.i_byte;
            endcase
            idx_d = idx_q + IDX_W'(1);
         end
      end else if (idx_q != '0) begin
         if (idle_q == IDLE_LAST) begin
            idx_d  = '0;
            idle_d = '0;
         end else begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end
   end

   // Issue only in vblank so colour changes never land mid-frame. A word
   // that finds the FIFO full with no pop on the same edge is lost.
   always_comb begin
      pop        = !fifoEmpty && bus.i_vblank;
      ready_d    = pop;
      overflow_d = overflow_q;
      if (pushReq && fifoFull && !pop) begin
         overflow_d = 1'b1;
      end
   end

   // Assembly state, sticky overflow and the ready pulse register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         idx_q      <= '0;
         held_q     <= '0;
         idle_q     <= '0;
         overflow_q <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         held_q     <= held_d;
         idle_q     <= idle_d;
         overflow_q <= overflow_d;
         ready_q    <= ready_d;
      end
   end

   sync_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (i_clk),
      .reset_i    (i_reset),
      .push_i     (pushReq),
      .pushData_i (pushWord),
      .pop_i      (pop),
      .popData_o  (headWord),
      .count_o    (fifoCount),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   assign bus.o_instruction       = headWord;
   assign bus.o_instruction_ready = ready_q;
   assign bus.o_overflow          = overflow_q;
   assign bus.o_fifo_count        = fifoCount;

endmodule

// File: tb/tb_instruction_assembler.sv
// ---------------------------------------------------------------------------
// tb_instruction_assembler
// Directed bench for instruction_assembler with FIFO_DEPTH=4 and a short
// timeout. Inputs change on the falling edge; a monitor records every ready
// pulse one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_instruction_assembler;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic clk;
   logic reset;
   int   checkCount;
   int   passCount;
   int   cycleCount;

   logic [31:0] obsQ[$];
   int          obsCyc[$];

   instruction_assembler_if #(.FIFO_DEPTH(DEPTH)) bus();

   instruction_assembler #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus.slave)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Records every issued word with the cycle it was seen in.
   always @(posedge clk) begin
      #1;
      cycleCount++;
      if (bus.o_instruction_ready === 1'b1) begin
         obsQ.push_back(bus.o_instruction);
         obsCyc.push_back(cycleCount);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] obsAt(input int k);
      if (k < obsQ.size()) return obsQ[k];
      return 32'hxxxxxxxx;
   endfunction

   function automatic int cycAt(input int k);
      if (k < obsCyc.size()) return obsCyc[k];
      return -1000;
   endfunction

   // Drives one byte for exactly one clock, starting at a falling edge.
   task automatic applyStimulus(input logic [7:0] b);
      bus.i_byte       = b;
      bus.i_byte_valid = 1'b1;
      @(negedge clk);
      bus.i_byte_valid = 1'b0;
   endtask

   task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      applyStimulus(b0);
      applyStimulus(b1);
      applyStimulus(b2);
      applyStimulus(b3);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checkCount       = 0;
      passCount        = 0;
      cycleCount       = 0;
      reset            = 1'b1;
      bus.i_byte       = 8'h00;
      bus.i_byte_valid = 1'b0;
      bus.i_vblank     = 1'b0;
      waitCycles(3);
      reset = 1'b0;

      checkOutput("rst_instr",    bus.o_instruction, 32'h0);
      checkOutput("rst_ready",    32'(bus.o_instruction_ready), 32'h0);
      checkOutput("rst_overflow", 32'(bus.o_overflow), 32'h0);
      checkOutput("rst_count",    32'(bus.o_fifo_count), 32'h0);

      // Basic issue and latency
      obsQ.delete(); obsCyc.delete();
      bus.i_vblank = 1'b1;
      sendWord(8'h01, 8'h0F, 8'h0A, 8'h00);
      checkOutput("lat_ready_t0", 32'(bus.o_instruction_ready), 32'h0);
      checkOutput("lat_count_t0", 32'(bus.o_fifo_count), 32'h1);
      @(negedge clk);
      checkOutput("lat_ready_t1", 32'(bus.o_instruction_ready), 32'h1);
      checkOutput("lat_instr_t1", bus.o_instruction, 32'h000A0F01);
      checkOutput("lat_count_t1", 32'(bus.o_fifo_count), 32'h0);
      @(negedge clk);
      checkOutput("lat_ready_t2", 32'(bus.o_instruction_ready), 32'h0);
      waitCycles(3);
      checkOutput("basic_pulses", 32'(obsQ.size()), 32'h1);
      checkOutput("basic_hold",   bus.o_instruction, 32'h000A0F01);

      // Vblank gating
      obsQ.delete(); obsCyc.delete();
      bus.i_vblank = 1'b0;
      sendWord(8'h01, 8'h11, 8'h22, 8'h33);
      sendWord(8'h02, 8'h44, 8'h55, 8'h66);
      sendWord(8'h03, 8'h77, 8'h88, 8'h99);
      waitCycles(3);
      checkOutput("gate_nopulse", 32'(obsQ.size()), 32'h0);
      checkOutput("gate_count3",  32'(bus.o_fifo_count), 32'h3);
      bus.i_vblank = 1'b1;
      waitCycles(6);
      checkOutput("gate_pulses",  32'(obsQ.size()), 32'h3);
      checkOutput("gate_word0",   obsAt(0), 32'h33221101);
      checkOutput("gate_word1",   obsAt(1), 32'h66554402);
      checkOutput("gate_word2",   obsAt(2), 32'h99887703);
      checkOutput("gate_b2b",     32'(cycAt(2) - cycAt(0)), 32'h2);
      checkOutput("gate_count0",  32'(bus.o_fifo_count), 32'h0);

      // Overflow
      obsQ.delete(); obsCyc.delete();
      bus.i_vblank = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         sendWord(8'h01, 8'(i), 8'hC0, 8'h5A);
      end
      waitCycles(2);
      checkOutput("ovf_count",  32'(bus.o_fifo_count), 32'h4);
      checkOutput("ovf_flag",   32'(bus.o_overflow), 32'h1);
      bus.i_vblank = 1'b1;
      waitCycles(8);
      checkOutput("ovf_pulses", 32'(obsQ.size()), 32'h4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("ovf_word%0d", i), obsAt(i),
                     {8'h5A, 8'hC0, 8'(i + 1), 8'h01});
      end
      checkOutput("ovf_sticky", 32'(bus.o_overflow), 32'h1);

      // Reset mid-operation
      bus.i_vblank = 1'b0;
      sendWord(8'h01, 8'h21, 8'h22, 8'h23);
      sendWord(8'h01, 8'h31, 8'h32, 8'h33);
      applyStimulus(8'h01);
      applyStimulus(8'h0F);
      checkOutput("mid_count2", 32'(bus.o_fifo_count), 32'h2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("mid_instr",    bus.o_instruction, 32'h0);
      checkOutput("mid_ready",    32'(bus.o_instruction_ready), 32'h0);
      checkOutput("mid_overflow", 32'(bus.o_overflow), 32'h0);
      checkOutput("mid_count",    32'(bus.o_fifo_count), 32'h0);
      obsQ.delete(); obsCyc.delete();
      bus.i_vblank = 1'b1;
      sendWord(8'h01, 8'hAB, 8'hCD, 8'hEF);
      waitCycles(3);
      checkOutput("mid_pulses", 32'(obsQ.size()), 32'h1);
      checkOutput("mid_fresh",  obsAt(0), 32'hEFCDAB01);

      // Timeout: a short stall survives, a long one discards the partial word
      obsQ.delete(); obsCyc.delete();
      applyStimulus(8'h02);
      waitCycles(TIMEOUT - 2);
      applyStimulus(8'h11);
      waitCycles(TIMEOUT - 2);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      waitCycles(3);
      checkOutput("to_slow_pulses", 32'(obsQ.size()), 32'h1);
      checkOutput("to_slow_word",   obsAt(0), 32'h33221102);
      obsQ.delete(); obsCyc.delete();
      applyStimulus(8'h01);
      applyStimulus(8'h0F);
      waitCycles(TIMEOUT + 4);
      sendWord(8'h01, 8'hF0, 8'h00, 8'h00);
      waitCycles(3);
      checkOutput("to_pulses",   32'(obsQ.size()), 32'h1);
      checkOutput("to_word",     obsAt(0), 32'h0000F001);
      checkOutput("to_overflow", 32'(bus.o_overflow), 32'h0);

      // Push into a full FIFO on the same edge as a pop
      obsQ.delete(); obsCyc.delete();
      bus.i_vblank = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         sendWord(8'h01, 8'(i), 8'hEE, 8'h77);
      end
      checkOutput("full_count4", 32'(bus.o_fifo_count), 32'h4);
      applyStimulus(8'h01);
      applyStimulus(8'h05);
      applyStimulus(8'hEE);
      bus.i_vblank = 1'b1;
      applyStimulus(8'h77);
      bus.i_vblank = 1'b0;
      checkOutput("full_count_kept", 32'(bus.o_fifo_count), 32'h4);
      checkOutput("full_overflow",   32'(bus.o_overflow), 32'h0);
      bus.i_vblank = 1'b1;
      waitCycles(8);
      checkOutput("full_pulses", 32'(obsQ.size()), 32'h5);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("full_word%0d", i), obsAt(i),
                     {8'h77, 8'hEE, 8'(i + 1), 8'h01});
      end
      checkOutput("full_drained", 32'(bus.o_fifo_count), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
